// File: rtl/dl_sched_pkg.sv
// Shared types for the download-to-SDRAM write scheduler: FSM states and the
// FIFO entry carried from the byte side to the SDRAM port.
package dl_sched_pkg;

   localparam int WADDR_MAX_W = 31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_FLUSH,
      ST_DONE
   } dl_state_t;

   typedef struct packed {
      logic [WADDR_MAX_W-1:0] addr;
      logic [1:0]             ds;
      logic [15:0]            din;
   } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO of generic entries; pushes into a full FIFO and pops from
// an empty FIFO are ignored. DEPTH must be a power of two so pointers wrap.
module dl_fifo
   import dl_sched_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = dl_entry_t
) (
   input  logic   clk_sys,
   input  logic   reset_n,
   input  logic   push,
   input  entry_t din,
   input  logic   pop,
   output entry_t dout,
   output logic   empty,
   output logic   full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dl_sdram_sched.sv
// Queues download bytes and issues them as 16-bit SDRAM writes, one at a time.
// Define DL_PACK_EN to merge even/odd byte pairs of a word into one write.
//
// state    | meaning
// ST_IDLE  | waiting for a queued entry
// ST_ISSUE | request raised or about to be raised, held until port_ack
// ST_FLUSH | download ended; draining pending byte and FIFO
// ST_DONE  | all data committed, rom_loaded high
module dl_sdram_sched
   import dl_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 25
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              port_req,
   input  logic              port_ack,
   output logic [ADDR_W-2:0] port_addr,
   output logic [1:0]        port_ds,
   output logic [15:0]       port_din,
   output logic              rom_loaded,
   output logic              busy,
   output logic              overflow
);

   dl_state_t state;
   dl_entry_t byte_ent;
   dl_entry_t push_entry;
   dl_entry_t head;
   logic      act_q;
   logic      rise;
   logic      fall;
   logic      wr_en;
   logic      push;
   logic      drop;
   logic      fifo_empty;
   logic      fifo_full;
   logic      pend_busy;

   assign rise  = dl_active & ~act_q;
   assign fall  = ~dl_active & act_q;
   assign wr_en = dl_wr & dl_active;
   assign byte_ent = '{addr: WADDR_MAX_W'(dl_addr[ADDR_W-1:1]),
                       ds:   {dl_addr[0], ~dl_addr[0]},
                       din:  {dl_data, dl_data}};

`ifdef DL_PACK_EN
   dl_entry_t pend_entry;
   logic      pend_valid;
   logic      pend_load;
   logic      pend_clear;

   // A pending even byte merges with the odd byte of the same word; anything
   // else flushes the pending byte alone and takes its place.
   always_comb begin
      push       = 1'b0;
      push_entry = pend_entry;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      if (wr_en) begin
         if (pend_valid && dl_addr[0] && pend_entry.ds == 2'b01 &&
             pend_entry.addr == byte_ent.addr) begin
            push       = 1'b1;
            push_entry = '{addr: byte_ent.addr, ds: 2'b11,
                           din: {dl_data, pend_entry.din[7:0]}};
            pend_clear = 1'b1;
         end else if (pend_valid) begin
            push      = 1'b1;
            pend_load = 1'b1;
         end else if (dl_addr[0]) begin
            push       = 1'b1;
            push_entry = byte_ent;
         end else begin
            pend_load = 1'b1;
         end
      end else if (fall && pend_valid) begin
         push       = 1'b1;
         pend_clear = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid <= 1'b0;
         pend_entry <= '0;
      end else if (pend_load) begin
         pend_valid <= 1'b1;
         pend_entry <= byte_ent;
      end else if (pend_clear) begin
         pend_valid <= 1'b0;
      end
   end

   assign pend_busy = pend_valid;
`else
   assign push       = wr_en;
   assign push_entry = byte_ent;
   assign pend_busy  = 1'b0;
`endif

   assign drop = push & fifo_full;
   assign busy = ~fifo_empty | port_req | pend_busy;

   dl_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(dl_entry_t)) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .push    (push),
      .din     (push_entry),
      .pop     (port_req & port_ack),
      .dout    (head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         act_q      <= 1'b0;
         port_req   <= 1'b0;
         port_addr  <= '0;
         port_ds    <= '0;
         port_din   <= '0;
         rom_loaded <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         act_q <= dl_active;
         if (rise) begin
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
         end
         if (drop) overflow <= 1'b1;
         if (port_req && port_ack) port_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fall)             state <= ST_FLUSH;
               else if (!fifo_empty) state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (fall) begin
                  state <= ST_FLUSH;
               end else if (port_req && port_ack) begin
                  state <= ST_IDLE;
               end else if (!port_req) begin
                  port_req  <= 1'b1;
                  port_addr <= head.addr[ADDR_W-2:0];
                  port_ds   <= head.ds;
                  port_din  <= head.din;
               end
            end
            ST_FLUSH: begin
               if (rise) begin
                  state <= port_req ? ST_ISSUE : ST_IDLE;
               end else if (port_req) begin
                  state <= ST_FLUSH;
               end else if (!fifo_empty) begin
                  port_req  <= 1'b1;
                  port_addr <= head.addr[ADDR_W-2:0];
                  port_ds   <= head.ds;
                  port_din  <= head.din;
               end else begin
                  state      <= ST_DONE;
                  rom_loaded <= 1'b1;
               end
            end
            ST_DONE: begin
               if (rise) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dl_sdram_sched.md
DL_SDRAM_SCHED -- requirements
Module: dl_sdram_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of pending SDRAM write entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 25, byte-address width of the download bus.
REQ-003 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dl_active  in  1  download in progress, level.
REQ-006 SHALL have port dl_wr  in  1  one-cycle byte strobe.
REQ-007 SHALL have port dl_addr  in  ADDR_W  byte address qualified by dl_wr.
REQ-008 SHALL have port dl_data  in  8  byte qualified by dl_wr.
REQ-009 SHALL have port port_req  out  1  SDRAM write request, level.
REQ-010 SHALL have port port_ack  in  1  one-cycle SDRAM completion pulse.
REQ-011 SHALL have port port_addr  out  ADDR_W-1  word address, dl_addr[ADDR_W-1:1].
REQ-012 SHALL have port port_ds  out  2  byte enables, bit1 = odd byte, bit0 = even byte.
REQ-013 SHALL have port port_din  out  16  write data.
REQ-014 SHALL have port rom_loaded  out  1  all download data committed.
REQ-015 SHALL have port busy  out  1  FIFO non-empty, request outstanding, or byte pending.
REQ-016 SHALL have port overflow  out  1  sticky, a byte was dropped.

Function
REQ-017 SHALL implement states IDLE, ISSUE, FLUSH, DONE.
REQ-018 IDLE->ISSUE when the FIFO is non-empty; port_req SHALL rise on the cycle after that transition.
REQ-019 ISSUE SHALL hold port_req, port_addr, port_ds and port_din stable until port_ack, with at most one request outstanding.
REQ-020 On port_ack, port_req SHALL drop in the same edge and the FIFO SHALL pop; the next request SHALL NOT issue earlier than one cycle later.
REQ-021 A port_ack arriving with port_req low SHALL be ignored.
REQ-022 dl_wr with a full FIFO SHALL drop the byte and set overflow; overflow SHALL clear only on reset or a dl_active rising edge.
REQ-023 A dl_active rising edge SHALL clear rom_loaded and overflow.
REQ-024 A dl_active falling edge SHALL enter FLUSH: push any pending byte, then drain the FIFO.
REQ-025 FLUSH->DONE when the FIFO is empty and port_req is low; DONE SHALL set rom_loaded = 1.
REQ-026 DONE->IDLE on a dl_active rising edge.
REQ-027 dl_wr while dl_active = 0 SHALL be ignored.
REQ-028 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While reset_n = 0: port_req = 0, port_ds = 0, port_addr = 0, port_din = 0, rom_loaded = 0, busy = 0, overflow = 0, FIFO empty, no pending byte, state IDLE.
REQ-031 Reset asserted mid-transfer SHALL abandon the outstanding request; a late port_ack is covered by REQ-021.

Configuration
REQ-032 With DL_PACK_EN defined, an even byte SHALL be held pending.
REQ-033 With DL_PACK_EN, an odd byte with the same word address SHALL push one entry with ds = 2'b11 and din = {odd, even}.
REQ-034 With DL_PACK_EN, an even byte or a different word address arriving while a byte is pending SHALL first push the pending byte alone (ds = 2'b01), in the same cycle if space exists, else drop with overflow.
REQ-035 Without DL_PACK_EN, every byte SHALL push one entry with ds = {a[0], ~a[0]} and din = {b, b}, with no pending register.

Structure
REQ-036 Package dl_sched_pkg SHALL hold the state enum and the FIFO entry struct {addr, ds, din}.
REQ-037 Sub-module dl_fifo SHALL be a synchronous FIFO parameterised by depth and entry type, with async active-low reset.

Verification
REQ-038 Packed: bytes 0x11 @0x0, 0x22 @0x1, ack after 3 cycles -> one request, addr 0, ds 2'b11, din 0x2211.
REQ-039 Unpacked build, same stimulus -> two requests: (0, 2'b01, 0x1111) then (0, 2'b10, 0x2222).
REQ-040 Packed: lone byte 0xAB @0x8 then dl_active falls -> FLUSH emits (4, 2'b01, 0xABAB); rom_loaded = 1 after ack.
REQ-041 FIFO_DEPTH 4, no ack, 10 unpacked bytes -> 4 queued, 1 outstanding, overflow = 1, later ack order matches addresses.
REQ-042 reset_n low while port_req = 1 -> all outputs zero immediately; stray port_ack after release produces no pop.
REQ-043 New download after DONE -> rom_loaded and overflow cleared on the dl_active rising edge.
